// File: rtl/sobel_pkg.sv
// Shared types and widths for the Sobel frame controller and its raster counter.
// Optional feature macro used by this slice: SOBEL_CTRL_TIMEOUT_EN (drain watchdog).
package sobel_pkg;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned OUT_W = 24;
    localparam int unsigned PIX_W = 16;
    localparam int unsigned WD_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sobel_pix_cnt.sv
// Column/row raster counter with a last-pixel flag; reusable for display timing.
module sobel_pix_cnt
    import sobel_pkg::*;
#(
    parameter logic [OUT_W-1:0] PIC_W = 24'd480,
    parameter logic [OUT_W-1:0] PIC_H = 24'd272
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] col_o,
    output logic [CNT_W-1:0] row_o,
    output logic             last_o_c
);

    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(PIC_W - OUT_W'(1));
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(PIC_H - OUT_W'(1));

    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] row_q;
    logic             col_end_c;
    logic             row_end_c;

    assign col_end_c = (col_q == COL_MAX);
    assign row_end_c = (row_q == ROW_MAX);
    assign last_o_c  = col_end_c && row_end_c;
    assign col_o     = col_q;
    assign row_o     = row_q;

    // Advance one pixel per increment; the row wraps after the last line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clr_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (inc_i) begin
            if (col_end_c) begin
                col_q <= '0;
                row_q <= row_end_c ? '0 : row_q + CNT_W'(1);
            end else begin
                col_q <= col_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer feeding one PIC_W x PIC_H frame into the gray/Sobel pipeline
// and counting its output strobes. Optional macro SOBEL_CTRL_TIMEOUT_EN adds a
// drain watchdog that aborts the frame after DRAIN_MAX quiet cycles.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter logic [OUT_W-1:0] PIC_W   = 24'd480,
    parameter logic [OUT_W-1:0] PIC_H   = 24'd272,
    parameter logic [OUT_W-1:0] OUT_PIX = 24'd129060
`ifdef SOBEL_CTRL_TIMEOUT_EN
    ,
    parameter logic [WD_W-1:0]  DRAIN_MAX = 16'd4096
`endif
) (
    input  logic             tft_clk,
    input  logic             tft_rst,
    input  logic             start,
    input  logic             src_valid,
    input  logic [PIX_W-1:0] src_data,
    output logic             src_ready,
    output logic             ip_flag,
    output logic [PIX_W-1:0] ip_data,
    input  logic             op_flag,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic [CNT_W-1:0] col_cnt,
    output logic [CNT_W-1:0] row_cnt
);

    state_t           state_q;
    logic             src_ready_q;
    logic             ip_flag_q;
    logic [PIX_W-1:0] ip_data_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             seen_q;
    logic [OUT_W-1:0] out_cnt_q;
    logic [OUT_W-1:0] out_cnt_d;

    logic start_acc_c;
    logic xfer_c;
    logic pix_last_c;
    logic out_full_c;
    logic op_cnt_c;
    logic op_err_c;
    logic drain_done_c;

    assign start_acc_c  = (state_q == ST_IDLE) && start;
    assign xfer_c       = src_valid && src_ready_q;
    assign out_full_c   = (out_cnt_q == OUT_PIX);
    assign op_cnt_c     = op_flag && !out_full_c &&
                          ((state_q == ST_FEED) || (state_q == ST_DRAIN));
    assign op_err_c     = op_flag && (out_full_c || ((state_q == ST_IDLE) && seen_q));
    assign out_cnt_d    = op_cnt_c ? out_cnt_q + OUT_W'(1) : out_cnt_q;
    assign drain_done_c = (out_cnt_d == OUT_PIX);

`ifdef SOBEL_CTRL_TIMEOUT_EN
    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;
    logic            timeout_c;

    assign wd_d      = op_flag ? '0 : wd_q + WD_W'(1);
    assign timeout_c = (state_q == ST_DRAIN) && (wd_d == DRAIN_MAX);

    // Quiet-cycle watchdog, only live while draining.
    always_ff @(posedge tft_clk or negedge tft_rst) begin
        if (!tft_rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= (state_q == ST_DRAIN) ? wd_d : '0;
        end
    end
`else
    logic timeout_c;
    assign timeout_c = 1'b0;
`endif

    // Raster position of the next pixel to be admitted.
    sobel_pix_cnt #(
        .PIC_W (PIC_W),
        .PIC_H (PIC_H)
    ) u_pix_cnt (
        .clk      (tft_clk),
        .rst_n    (tft_rst),
        .clr_i    (start_acc_c),
        .inc_i    (xfer_c),
        .col_o    (col_cnt),
        .row_o    (row_cnt),
        .last_o_c (pix_last_c)
    );

    // Frame sequencer with registered handshake, strobe and status outputs.
    always_ff @(posedge tft_clk or negedge tft_rst) begin
        if (!tft_rst) begin
            state_q     <= ST_IDLE;
            src_ready_q <= 1'b0;
            ip_flag_q   <= 1'b0;
            ip_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            seen_q      <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            ip_flag_q <= xfer_c;
            if (xfer_c) begin
                ip_data_q <= src_data;
            end
            done_q    <= 1'b0;
            out_cnt_q <= out_cnt_d;
            if (op_err_c) begin
                err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_FEED;
                        busy_q      <= 1'b1;
                        src_ready_q <= 1'b1;
                        err_q       <= 1'b0;
                        out_cnt_q   <= '0;
                    end
                end
                ST_FEED: begin
                    if (xfer_c && pix_last_c) begin
                        state_q     <= ST_DRAIN;
                        src_ready_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_c) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (timeout_c) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        seen_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    seen_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign src_ready  = src_ready_q;
    assign ip_flag    = ip_flag_q;
    assign ip_data    = ip_data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame-level sequencer in front of the gray+Sobel edge pipeline on the tft_clk domain. It accepts a start command, admits exactly one PIC_W x PIC_H frame of RGB565 pixels from the upstream source into the pipeline via ip_flag/ip_data, and tracks the pipeline's output strobes. It reports frame completion or error and blocks new frames while one is in flight.

Parameters:
PIC_W, 24'd480, pixels per line
PIC_H, 24'd272, lines per frame
OUT_PIX, 24'd129060, expected op_flag pulses per frame, (PIC_W-2)*(PIC_H-2)
DRAIN_MAX, 16'd4096, watchdog limit in cycles for drain (used only with the optional feature)

Ports:
tft_clk  in  1  pixel clock, single clock domain
tft_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; requests one frame
src_valid  in  1  upstream pixel valid
src_data  in  16  upstream RGB565 pixel
src_ready  out  1  controller accepts pixel this cycle
ip_flag  out  1  pixel strobe to gray/Sobel pipeline
ip_data  out  16  pixel to pipeline
op_flag  in  1  pipeline output strobe (monitored only)
busy  out  1  frame in flight
frame_done  out  1  one-cycle pulse on successful frame
frame_err  out  1  sticky error flag, cleared by next accepted start
col_cnt  out  12  current input column
row_cnt  out  12  current input line

Behaviour:
- Reset (tft_rst=0, async): state IDLE; all outputs 0; all counters 0.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: src_ready=0. On start=1, go to FEED next cycle, clear counters and frame_err, busy=1. start while not IDLE is ignored.
- FEED: src_ready=1. Transfer when src_valid&&src_ready. On a transfer, ip_flag=1 and ip_data=src_data are registered, so there is 1-cycle latency. No transfer: ip_flag=0, ip_data holds its value.
- Per transfer, col_cnt increments. At PIC_W-1 it wraps to 0 and row_cnt increments.
- The transfer with col=PIC_W-1 and row=PIC_H-1 is the last one. The next state is DRAIN, and src_ready drops in the following cycle, so exactly PIC_W*PIC_H pixels are admitted.
- out_cnt (24-bit) increments on every op_flag in FEED or DRAIN.
- DRAIN: src_ready=0, ip_flag=0. When out_cnt reaches OUT_PIX, go to DONE. If op_flag arrives in the same cycle the count reaches OUT_PIX, that pulse is included.
- DONE: frame_done=1 for exactly one cycle. busy=0 from the following cycle. Return to IDLE.
- If op_flag is seen when out_cnt==OUT_PIX already, or during IDLE after a frame: frame_err=1 (sticky). No other effect.
- Simultaneous last-transfer and op_flag: both are counted.
- start coincident with DONE is ignored.
- Reset mid-frame aborts immediately. The pipeline is not flushed; the upstream source must restart on a frame boundary.

Optional Feature:
SOBEL_CTRL_TIMEOUT_EN
- Defined: a 16-bit drain watchdog counts cycles in DRAIN and resets on each op_flag. On reaching DRAIN_MAX it sets frame_err=1, goes to IDLE (busy=0) and does not pulse frame_done.
- Undefined: no watchdog; DRAIN waits indefinitely. DRAIN_MAX is unused.

Decomposition:
- Shared package sobel_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_FEED=2'd1, ST_DRAIN=2'd2, ST_DONE=2'd3
  - counter width constants CNT_W=12 and OUT_W=24
- One sub-module: sobel_pix_cnt, the column/row raster counter with a last-pixel flag. The same counter is reusable for the display-side timing.

Test Plan:
1. Reset, then start with continuous src_valid, PIC_W=8, PIC_H=4, OUT_PIX=12, and a pipeline model emitting 12 op_flags -> exactly 32 ip_flag pulses; src_ready low from the cycle after the 32nd transfer; frame_done pulses once; busy low the next cycle.
2. Random src_valid gaps (50% duty) -> ip_data matches the accepted src_data sequence one cycle later; col/row wrap correctly at col=7.
3. start pulsed mid-FEED and again during DRAIN -> ignored; pixel count stays 32; single frame_done.
4. Model emits 13 op_flags -> frame_err=1 after the 13th. Next start clears frame_err.
5. tft_rst asserted at pixel 10 of FEED -> all outputs 0 asynchronously. A new start restarts at col=0, row=0.
6. With SOBEL_CTRL_TIMEOUT_EN, DRAIN_MAX=16, model stops at 11 op_flags -> 16 idle cycles later frame_err=1, state IDLE, no frame_done. Without the macro, busy stays 1.
